// File: rtl/byte_serial_adder32.sv
// Byte-serial W-bit adder: one 8-bit slice, registered carry between bytes.
// Optional OF/ZF flag outputs enabled by defining SERIAL_ADDER_FLAGS_EN.
`timescale 1ns/1ps
module byte_serial_adder32 #(
  parameter int NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [8*NBYTES-1:0]   In1,
  input  logic [8*NBYTES-1:0]   In2,
  input  logic                  CI,
  output logic [8*NBYTES-1:0]   Out,
  output logic                  CO,
  output logic                  Busy,
`ifdef SERIAL_ADDER_FLAGS_EN
  output logic                  OF,
  output logic                  ZF,
`endif
  output logic                  Done
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          load;
  logic          step;
  logic          last;

  logic [W-1:0]  a_sh;
  logic [W-1:0]  b_sh;
  logic [W-9:0]  acc;
  logic          carry;
  logic [CW-1:0] cnt;

  logic [7:0]    slice_sum;
  logic          slice_co;
  logic [W-1:0]  acc_ext;

`ifdef SERIAL_ADDER_FLAGS_EN
  logic          a_msb;
  logic          b_msb;
`endif

  // The 8-bit slice; the only carry path between bytes is the carry register.
  assign {slice_co, slice_sum} = {1'b0, a_sh[7:0]}
                               + {1'b0, b_sh[7:0]}
                               + {8'd0, carry};

  assign acc_ext = {slice_sum, acc};
  assign last    = (cnt == LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    Busy    = 1'b0;
    Done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (Start) begin
          load    = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        Busy = 1'b1;
        step = 1'b1;
        if (last) begin
          state_n = DONE;
        end
      end
      DONE: begin
        Done = 1'b1;
        if (Start) begin
          load    = 1'b1;
          state_n = RUN;
        end else begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Out   <= '0;
      CO    <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      OF    <= 1'b0;
      ZF    <= 1'b0;
`endif
    end else if (load) begin
      a_sh  <= In1;
      b_sh  <= In2;
      carry <= CI;
      cnt   <= '0;
`ifdef SERIAL_ADDER_FLAGS_EN
      a_msb <= In1[W-1];
      b_msb <= In2[W-1];
`endif
    end else if (step) begin
      a_sh  <= a_sh >> 8;
      b_sh  <= b_sh >> 8;
      acc   <= acc_ext[W-1:8];
      carry <= slice_co;
      cnt   <= cnt + CW'(1);
      if (last) begin
        Out <= acc_ext;
        CO  <= slice_co;
`ifdef SERIAL_ADDER_FLAGS_EN
        OF  <= a_msb ^ b_msb ^ acc_ext[W-1] ^ slice_co;
        ZF  <= (acc_ext == '0);
`endif
      end
    end
  end

endmodule

// File: tb/tb_byte_serial_adder32.sv
// Bench for byte_serial_adder32: vector table, scoreboard, handshake corners.
// Flag checks compile in when SERIAL_ADDER_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_byte_serial_adder32;

  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         Start = 1'b0;
  logic         CI = 1'b0;
  logic [W-1:0] In1 = '0;
  logic [W-1:0] In2 = '0;
  logic [W-1:0] Out;
  logic         CO;
  logic         Busy;
  logic         Done;
`ifdef SERIAL_ADDER_FLAGS_EN
  logic         OF;
  logic         ZF;
`endif

  typedef struct packed {
    logic [W-1:0] out;
    logic         co;
    logic         of;
    logic         zf;
  } res_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    res_t         r;
  } vec_t;

  int           passed = 0;
  int           total = 0;
  res_t         sbq[$];
  res_t         exp_r;
  logic [W-1:0] last_out = '0;

  byte_serial_adder32 #(.NBYTES(4)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .Start(Start),
    .In1  (In1),
    .In2  (In2),
    .CI   (CI),
    .Out  (Out),
    .CO   (CO),
    .Busy (Busy),
`ifdef SERIAL_ADDER_FLAGS_EN
    .OF   (OF),
    .ZF   (ZF),
`endif
    .Done (Done)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic res_t rs(input logic [W-1:0] o,
                              input logic co, input logic of,
                              input logic zf);
    res_t r;
    r.out = o; r.co = co; r.of = of; r.zf = zf;
    return r;
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a,
                              input logic [W-1:0] b,
                              input logic ci, input res_t r);
    vec_t v;
    v.a = a; v.b = b; v.ci = ci; v.r = r;
    return v;
  endfunction

  // Scoreboard consumer: every Done pops one expected result.
  always @(negedge CLK) begin
    if (!RST && Busy && Done) check("busy_done_overlap", 1, 0);
    if (!RST && Done) begin
      if (sbq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_r = sbq.pop_front();
        check("out", Out, exp_r.out);
        check("co", W'(CO), W'(exp_r.co));
`ifdef SERIAL_ADDER_FLAGS_EN
        check("of", W'(OF), W'(exp_r.of));
        check("zf", W'(ZF), W'(exp_r.zf));
`endif
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic ci, input res_t r);
    In1   = a;
    In2   = b;
    CI    = ci;
    Start = 1'b1;
    sbq.push_back(r);
  endtask

  task automatic run_op(input vec_t v);
    int cyc = 0;
    int busy = 0;
    @(negedge CLK);
    start_op(v.a, v.b, v.ci, v.r);
    do begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) Start = 1'b0;
      busy += int'(Busy);
      if (cyc == 2) check("hold_out", Out, last_out);
    end while (!Done && cyc < 20);
    check("done_latency", W'(cyc), W'(5));
    check("busy_cycles", W'(busy), W'(4));
    last_out = v.r.out;
  endtask

  task automatic count_done(input int n, output int dones);
    dones = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      dones += int'(Done);
    end
  endtask

  initial begin
    vec_t vt[6];
    int   dones;
    int   cyc;

    vt[0] = mk(32'h000000FF, 32'h00000001, 1'b0,
               rs(32'h00000100, 1'b0, 1'b0, 1'b0));
    vt[1] = mk(32'hFFFFFFFF, 32'h00000000, 1'b1,
               rs(32'h00000000, 1'b1, 1'b0, 1'b1));
    vt[2] = mk(32'h7FFFFFFF, 32'h00000001, 1'b0,
               rs(32'h80000000, 1'b0, 1'b1, 1'b0));
    vt[3] = mk(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1,
               rs(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    vt[4] = mk(32'h00FF00FF, 32'h00010001, 1'b0,
               rs(32'h01000100, 1'b0, 1'b0, 1'b0));
    vt[5] = mk(32'h12345678, 32'h9ABCDEF0, 1'b0,
               rs(32'hACF13568, 1'b0, 1'b0, 1'b0));

    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_out", Out, 0);
    check("rst_co", W'(CO), 0);
    check("rst_busy", W'(Busy), 0);
    check("rst_done", W'(Done), 0);
`ifdef SERIAL_ADDER_FLAGS_EN
    check("rst_of", W'(OF), 0);
    check("rst_zf", W'(ZF), 0);
`endif
    RST = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vt[i]);

    // Start during RUN must be ignored.
    @(negedge CLK);
    start_op(32'h11111111, 32'h22222222, 1'b0,
             rs(32'h33333333, 1'b0, 1'b0, 1'b0));
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    In1   = 32'hFFFFFFFF;
    In2   = 32'h00000001;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    count_done(10, dones);
    check("ignored_start_dones", W'(dones), 1);
    last_out = 32'h33333333;

    // Reset in the second RUN cycle discards the operation.
    @(negedge CLK);
    In1   = 32'h12345678;
    In2   = 32'h11111111;
    CI    = 1'b0;
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    check("busy_before_rst", W'(Busy), 1);
    RST = 1'b1;
    #1;
    check("midrst_out", Out, 0);
    check("midrst_co", W'(CO), 0);
    check("midrst_busy", W'(Busy), 0);
    check("midrst_done", W'(Done), 0);
    @(negedge CLK);
    RST = 1'b0;
    count_done(10, dones);
    check("midrst_no_done", W'(dones), 0);
    last_out = '0;
    run_op(mk(32'h00000001, 32'h00000001, 1'b0,
              rs(32'h00000002, 1'b0, 1'b0, 1'b0)));

    // Back-to-back: Start held in the Done cycle.
    @(negedge CLK);
    start_op(32'h00000005, 32'h00000007, 1'b0,
             rs(32'h0000000C, 1'b0, 1'b0, 1'b0));
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) Start = 1'b0;
    end while (!Done && cyc < 20);
    check("b2b_first_latency", W'(cyc), 5);
    start_op(32'h80000000, 32'h80000000, 1'b0,
             rs(32'h00000000, 1'b1, 1'b1, 1'b1));
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) Start = 1'b0;
      if (cyc == 2) check("b2b_hold", Out, 32'h0000000C);
    end while (!Done && cyc < 20);
    check("b2b_second_latency", W'(cyc), 5);

    count_done(3, dones);
    check("no_extra_done", W'(dones), 0);
    check("queue_empty", W'(sbq.size()), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
